// File: rtl/paillier_arb_pkg.sv
// Shared sizing constants and FSM state type for the Paillier result arbiter.
// The result path drains BLOCK_COUNT engines, one N-word burst of K-bit words at a time.
package paillier_arb_pkg;

  localparam int BLOCK_COUNT = 18;
  localparam int K           = 128;
  localparam int N           = 32;

  localparam int ID_W   = $clog2(BLOCK_COUNT);
  localparam int CW     = $clog2(N) + 1;
  localparam int BEAT_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    LAST
  } arb_state_t;

endpackage

// File: rtl/paillier_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index strictly
// after ptr (cyclic), using a double-width rotate followed by a priority encoder.
module paillier_rr_pick
  import paillier_arb_pkg::*;
(
  input  logic [BLOCK_COUNT-1:0] req,
  input  logic [ID_W-1:0]        ptr,
  output logic [ID_W-1:0]        gnt_idx,
  output logic                   any
);

  localparam logic [ID_W:0] BC_W = (ID_W + 1)'(BLOCK_COUNT);

  logic [2*BLOCK_COUNT-1:0] dbl;
  logic [BLOCK_COUNT-1:0]   rot;
  logic [ID_W:0]            start;
  logic [ID_W-1:0]          off;
  logic [ID_W:0]            sum;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    start = {1'b0, ptr} + 1'b1;
    dbl   = {req, req} >> start;
    rot   = dbl[BLOCK_COUNT-1:0];
    // Scan downwards so the lowest set bit (nearest to ptr) wins.
    off   = '0;
    for (int i = BLOCK_COUNT - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
    sum = start + {1'b0, off};
    if (sum >= BC_W) sum = sum - BC_W;
    gnt_idx = sum[ID_W-1:0];
    any     = |req;
  end

endmodule

// File: rtl/paillier_result_arbiter.sv
// Drains complete N-word results from the per-engine show-ahead FIFOs into one
// AXI-stream style K-bit stream, one engine per burst, round-robin between engines.
module paillier_result_arbiter
  import paillier_arb_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arb_en,
  input  logic [BLOCK_COUNT*CW-1:0] fifo_rd_cnt,
  input  logic [BLOCK_COUNT*K-1:0]  fifo_rd_dout,
  output logic [BLOCK_COUNT-1:0]    fifo_rd_rdy,
  output logic [K-1:0]              m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic [ID_W-1:0]           m_id,
  output logic                      busy,
  output logic [15:0]               done_cnt,
  output logic                      underflow_err
);

  localparam logic [CW-1:0]     FULL_CNT  = CW'(N);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

  arb_state_t             state, state_n;
  logic [ID_W-1:0]        grant;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_any;
  logic [BEAT_W-1:0]      beat_cnt;
  logic [CW-1:0]          cnt_a  [BLOCK_COUNT];
  logic [K-1:0]           dout_a [BLOCK_COUNT];
  logic [BLOCK_COUNT-1:0] eligible;
  logic [CW-1:0]          gnt_cnt;
  logic [K-1:0]           gnt_dout;
  logic                   slot_free;
  logic                   load;
  logic                   starved;
  logic                   start_grant;

  always_comb begin
    for (int i = 0; i < BLOCK_COUNT; i++) begin
      cnt_a[i]    = fifo_rd_cnt[i*CW +: CW];
      dout_a[i]   = fifo_rd_dout[i*K +: K];
      eligible[i] = cnt_a[i] >= FULL_CNT;
    end
  end

  paillier_rr_pick u_pick (
    .req     (eligible),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign gnt_cnt     = cnt_a[grant];
  assign gnt_dout    = dout_a[grant];
  assign slot_free   = !m_valid || m_ready;
  assign load        = (state == DRAIN) && slot_free && (gnt_cnt != '0);
  // A load slot is open but the granted FIFO ran dry mid-result.
  assign starved     = (state == DRAIN) && slot_free && (gnt_cnt == '0);
  assign start_grant = (state == IDLE) && arb_en && pick_any;
  assign busy        = (state != IDLE) || m_valid;

  always_comb begin
    fifo_rd_rdy = '0;
    if (load) fifo_rd_rdy[grant] = 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_grant) state_n = DRAIN;
      DRAIN:   if (load && beat_cnt == LAST_BEAT) state_n = LAST;
      LAST:    if (m_valid && m_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant         <= '0;
      rr_ptr        <= ID_W'(BLOCK_COUNT - 1);
      beat_cnt      <= '0;
      m_data        <= '0;
      m_valid       <= 1'b0;
      m_last        <= 1'b0;
      m_id          <= '0;
      done_cnt      <= '0;
      underflow_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_grant) begin
            grant    <= pick_idx;
            m_id     <= pick_idx;
            beat_cnt <= '0;
          end
        end
        DRAIN: begin
          if (load) begin
            m_data   <= gnt_dout;
            m_valid  <= 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) m_last <= 1'b1;
          end else if (m_ready) begin
            m_valid <= 1'b0;
          end
          if (starved) underflow_err <= 1'b1;
        end
        LAST: begin
          if (m_valid && m_ready) begin
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            done_cnt <= done_cnt + 1'b1;
            rr_ptr   <= grant;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_paillier_result_arbiter.sv
// Scoreboard bench: behavioural show-ahead FIFOs per engine, expected words and
// expected grant order queued at stimulus time and compared as beats are accepted.
`timescale 1ns/1ps
module tb_paillier_result_arbiter;
  import paillier_arb_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      arb_en;
  logic [BLOCK_COUNT*CW-1:0] fifo_rd_cnt;
  logic [BLOCK_COUNT*K-1:0]  fifo_rd_dout;
  logic [BLOCK_COUNT-1:0]    fifo_rd_rdy;
  logic [K-1:0]              m_data;
  logic                      m_valid;
  logic                      m_ready;
  logic                      m_last;
  logic [ID_W-1:0]           m_id;
  logic                      busy;
  logic [15:0]               done_cnt;
  logic                      underflow_err;

  always #5 clk = ~clk;

  paillier_result_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .arb_en        (arb_en),
    .fifo_rd_cnt   (fifo_rd_cnt),
    .fifo_rd_dout  (fifo_rd_dout),
    .fifo_rd_rdy   (fifo_rd_rdy),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .m_id          (m_id),
    .busy          (busy),
    .done_cnt      (done_cnt),
    .underflow_err (underflow_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [K-1:0] got, input logic [K-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [K-1:0]           fifo_q [BLOCK_COUNT][$];
  logic [K-1:0]           exp_q  [BLOCK_COUNT][$];
  int                     exp_id_q [$];
  logic [BLOCK_COUNT-1:0] force_empty = '0;
  int                     seq = 0;

  task automatic push_words(input int e, input int n);
    logic [K-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = {8'(e), 24'(seq), $urandom(), $urandom(), $urandom()};
      seq++;
      fifo_q[e].push_back(w);
      exp_q[e].push_back(w);
    end
  endtask

  // FIFO model: pop on the strobe seen at the edge, republish count/head shortly after.
  always @(posedge clk) begin : fifo_model
    logic [BLOCK_COUNT-1:0] mask;
    int sz;
    mask = fifo_rd_rdy;
    #1;
    for (int i = 0; i < BLOCK_COUNT; i++) begin
      if (mask[i]) begin
        check("pop_nonempty", fifo_q[i].size() != 0, 1'b1);
        if (fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
      end
    end
    #1;
    for (int i = 0; i < BLOCK_COUNT; i++) begin
      sz = fifo_q[i].size();
      fifo_rd_cnt[i*CW +: CW]  = force_empty[i] ? '0 : CW'((sz > 63) ? 63 : sz);
      fifo_rd_dout[i*K +: K]   = (sz != 0) ? fifo_q[i][0] : '0;
    end
  end

  int              cyc = 0;
  int              pop_cnt = 0;
  int              first_pop = -1;
  int              last_pop = -1;
  int              beat_idx = 0;
  int              cur_id = -1;
  int              stall_cnt = 0;
  logic            stalled = 1'b0;
  logic [K-1:0]    held_data;
  logic [ID_W-1:0] held_id;
  logic            held_last;

  // Monitor samples on the falling edge; inputs only change just after rising edges.
  always @(negedge clk) begin : monitor
    logic have;
    cyc++;
    if (rst) begin
      stalled  = 1'b0;
      beat_idx = 0;
    end else begin
      if (fifo_rd_rdy != '0) begin
        check("rdy_onehot", $onehot(fifo_rd_rdy), 1'b1);
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (stalled) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", m_data, held_data);
        check("stall_id", m_id, held_id);
        check("stall_last", m_last, held_last);
      end
      stalled   = m_valid && !m_ready;
      held_data = m_data;
      held_id   = m_id;
      held_last = m_last;
      if (stalled) stall_cnt++;
      if (m_valid && m_ready) begin
        if (beat_idx == 0) begin
          check("id_expected", exp_id_q.size() != 0, 1'b1);
          cur_id = (exp_id_q.size() != 0) ? exp_id_q.pop_front() : -1;
        end
        check("m_id", m_id, cur_id);
        have = (m_id < BLOCK_COUNT) && (exp_q[m_id].size() != 0);
        check("data_expected", have, 1'b1);
        if (have) check("m_data", m_data, exp_q[m_id].pop_front());
        check("m_last", m_last, beat_idx == N - 1);
        beat_idx = (beat_idx + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    pop_cnt   = 0;
    first_pop = -1;
    last_pop  = -1;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (done_cnt != 16'(target) && n < budget) begin
      step();
      n++;
    end
    check(tag, done_cnt, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_m_data"}, m_data, '0);
    check({tag, "_m_last"}, m_last, 1'b0);
    check({tag, "_m_id"}, m_id, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_rdy"}, fifo_rd_rdy, '0);
    check({tag, "_done_cnt"}, done_cnt, '0);
    check({tag, "_underflow"}, underflow_err, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fair_ids[3] = '{0, 5, 17};
    bit refilled[3] = '{0, 0, 0};
    int push_cyc;
    int n;
    int left;

    rst     = 1'b1;
    arb_en  = 1'b1;
    m_ready = 1'b1;
    step();
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    step();

    // Fairness: three engines loaded together, each refilled once after draining.
    clear_counts();
    foreach (fair_ids[i]) push_words(fair_ids[i], N);
    for (int r = 0; r < 2; r++) foreach (fair_ids[i]) exp_id_q.push_back(fair_ids[i]);
    n = 0;
    while (done_cnt != 16'd6 && n < 2000) begin
      foreach (fair_ids[i]) begin
        if (fifo_q[fair_ids[i]].size() == 0 && !refilled[i]) begin
          push_words(fair_ids[i], N);
          refilled[i] = 1'b1;
        end
      end
      step();
      n++;
    end
    check("fair_done", done_cnt, 16'd6);
    check("fair_pops", pop_cnt, 6 * N);

    // Single engine 3: 32 consecutive pops starting two cycles after the data appears.
    clear_counts();
    push_cyc = cyc;
    push_words(3, N);
    exp_id_q.push_back(3);
    wait_done("single_done", 7, 200);
    check("single_pops", pop_cnt, N);
    check("single_first_pop", first_pop, push_cyc + 2);
    check("single_pop_span", last_pop - first_pop, N - 1);

    // Backpressure: m_ready toggles every cycle.
    clear_counts();
    stall_cnt = 0;
    push_words(7, N);
    exp_id_q.push_back(7);
    n = 0;
    while (done_cnt != 16'd8 && n < 500) begin
      m_ready = ~m_ready;
      step();
      n++;
    end
    m_ready = 1'b1;
    check("bp_done", done_cnt, 16'd8);
    check("bp_pops", pop_cnt, N);
    check("bp_stalls_seen", stall_cnt > 0, 1'b1);

    // Threshold: N-1 words never qualify; the N-th word triggers a grant.
    clear_counts();
    push_words(2, N - 1);
    repeat (5) step();
    check("thr_busy", busy, 1'b0);
    check("thr_pops", pop_cnt, 0);
    exp_id_q.push_back(2);
    push_cyc = cyc;
    push_words(2, 1);
    wait_done("thr_done", 9, 200);
    check("thr_first_pop", first_pop, push_cyc + 2);

    // arb_en low blocks new grants but never truncates a running burst.
    arb_en = 1'b0;
    clear_counts();
    push_words(6, N);
    repeat (10) step();
    check("gate_busy", busy, 1'b0);
    check("gate_pops", pop_cnt, 0);
    exp_id_q.push_back(6);
    arb_en = 1'b1;
    n = 0;
    while (pop_cnt < 5 && n < 50) begin
      step();
      n++;
    end
    arb_en = 1'b0;
    wait_done("gate_done", 10, 200);
    check("gate_total_pops", pop_cnt, N);
    arb_en = 1'b1;

    // Underflow: count collapses to zero after 10 pops, then recovers.
    clear_counts();
    push_words(9, N);
    exp_id_q.push_back(9);
    n = 0;
    while (pop_cnt < 10 && n < 50) begin
      step();
      n++;
    end
    check("uf_clear_before", underflow_err, 1'b0);
    force_empty[9] = 1'b1;
    repeat (6) step();
    check("uf_flag", underflow_err, 1'b1);
    check("uf_pops_frozen", pop_cnt, 10);
    check("uf_valid_low", m_valid, 1'b0);
    check("uf_busy", busy, 1'b1);
    force_empty[9] = 1'b0;
    wait_done("uf_done", 11, 300);
    check("uf_total_pops", pop_cnt, N);
    check("uf_sticky", underflow_err, 1'b1);

    // Reset mid-burst, then engine 0 must win over engine 12.
    clear_counts();
    push_words(4, N);
    exp_id_q.push_back(4);
    n = 0;
    while (beat_idx != 15 && n < 100) begin
      step();
      n++;
    end
    check("rst_beat15_reached", beat_idx, 15);
    rst = 1'b1;
    #2;
    check_reset_outputs("midrst");
    for (int i = 0; i < BLOCK_COUNT; i++) begin
      fifo_q[i].delete();
      exp_q[i].delete();
    end
    exp_id_q.delete();
    step();
    rst = 1'b0;
    step();
    clear_counts();
    push_words(12, N);
    push_words(0, N);
    exp_id_q.push_back(0);
    exp_id_q.push_back(12);
    wait_done("post_rst_done", 2, 400);
    check("post_rst_pops", pop_cnt, 2 * N);

    left = exp_id_q.size();
    for (int i = 0; i < BLOCK_COUNT; i++) left += exp_q[i].size();
    check("scoreboard_empty", left, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
